mpu_control_fsm: RTL and testbench

Multi-cycle control unit for the 8-bit soft MPU. It fetches instructions over a req/ack memory handshake and decodes them. It generates the 3-bit ALU select and the datapath strobes (IR/imm load, PC inc/load, register/flag write). It drives the ALU select port and sits between instruction memory and the datapath.

---
 rtl/mpu_pkg.sv | 45 ++++
 rtl/mpu_insn_decode.sv | 38 +++
 rtl/mpu_control_fsm.sv | 126 ++++++++++++
 tb/tb_mpu_control_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared encodings for the 8-bit soft MPU: ALU selects, opcode/sub-op values,
// instruction field positions and the control FSM state type.
package mpu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_INC  = 3'b101;
  localparam logic [2:0] ALU_DEC  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [2:0] OP_EXT   = 3'b111;
  localparam logic [1:0] SUB_LDI  = 2'b00;
  localparam logic [1:0] SUB_JZ   = 2'b01;
  localparam logic [1:0] SUB_RSVD = 2'b10;
  localparam logic [1:0] SUB_HALT = 2'b11;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 1;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_IMM      = 3'd4,
    ST_IMM_EXEC = 3'd5,
    ST_HALT     = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LDI  = 3'd1,
    CLS_JZ   = 3'd2,
    CLS_RSVD = 3'd3,
    CLS_HALT = 3'd4
  } op_class_t;

endpackage

// File: rtl/mpu_insn_decode.sv
// Combinational instruction decoder: splits IR into op class, ALU select and
// register indices.
module mpu_insn_decode
  import mpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] ir,
  output op_class_t         op_class,
  output logic [2:0]        alu_sel,
  output logic [1:0]        rd,
  output logic [1:0]        rs
);

  logic [2:0] op;
  logic       unused_ir;

  assign op        = ir[OP_MSB:OP_LSB];
  assign rd        = ir[RD_MSB:RD_LSB];
  assign rs        = ir[RS_MSB:RS_LSB];
  assign unused_ir = ^ir;

  // Register ops carry their ALU select directly in the opcode field.
  assign alu_sel = (op == OP_EXT) ? ALU_PASS : op;

  always_comb begin
    op_class = CLS_ALU;
    if (op == OP_EXT) begin
      case (rs)
        SUB_LDI:  op_class = CLS_LDI;
        SUB_JZ:   op_class = CLS_JZ;
        SUB_RSVD: op_class = CLS_RSVD;
        default:  op_class = CLS_HALT;
      endcase
    end
  end

endmodule

// File: rtl/mpu_control_fsm.sv
// Multi-cycle control unit for the 8-bit soft MPU: fetches over req/ack,
// decodes, and drives the ALU select and datapath strobes.
module mpu_control_fsm
  import mpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit RSVD_HALTS = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              zero_flag,
  output logic              mem_req,
  output logic              ir_load,
  output logic              imm_load,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [2:0]        alu_sel,
  output logic              a_src_imm,
  output logic              reg_we,
  output logic              flag_we,
  output logic [1:0]        reg_dst,
  output logic [1:0]        reg_src,
  output logic              halted
);

  // Handshake: mem_req stays high until mem_ack; the cycle with both high
  // transfers mem_rdata. mem_ack in any other state is ignored.

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  ir;
  op_class_t          dec_class;
  logic [2:0]         dec_alu_sel;
  logic [1:0]         dec_rd;
  logic [1:0]         dec_rs;

  mpu_insn_decode #(.DATA_W(DATA_W)) u_decode (
    .ir       (ir),
    .op_class (dec_class),
    .alu_sel  (dec_alu_sel),
    .rd       (dec_rd),
    .rs       (dec_rs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    ir_load   = 1'b0;
    imm_load  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    alu_sel   = 3'b000;
    a_src_imm = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;
    reg_dst   = 2'b00;
    reg_src   = 2'b00;
    halted    = 1'b0;

    if (state != ST_RESET) begin
      reg_dst = dec_rd;
      reg_src = dec_rs;
    end

    case (state)
      ST_RESET: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_ALU:  state_nxt = ST_EXEC;
          CLS_LDI,
          CLS_JZ:   state_nxt = ST_IMM;
          CLS_RSVD: state_nxt = RSVD_HALTS ? ST_HALT : ST_FETCH;
          default:  state_nxt = ST_HALT;
        endcase
      end
      ST_EXEC: begin
        alu_sel   = dec_alu_sel;
        reg_we    = 1'b1;
        flag_we   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_IMM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_load  = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = ST_IMM_EXEC;
        end
      end
      ST_IMM_EXEC: begin
        // Only LDI and JZ can reach here; JZ never writes registers or flags.
        if (dec_class == CLS_LDI) begin
          alu_sel   = ALU_PASS;
          a_src_imm = 1'b1;
          reg_we    = 1'b1;
          flag_we   = 1'b1;
        end else begin
          pc_load = zero_flag;
        end
        state_nxt = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_mpu_control_fsm.sv
// Directed bench for mpu_control_fsm: a per-cycle vector table through
// ALU/LDI/JZ/reserved/HALT flows, then async reset corner sequences.
module tb_mpu_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       ir_load;
    logic       imm_load;
    logic       pc_inc;
    logic       pc_load;
    logic [2:0] alu_sel;
    logic       a_src_imm;
    logic       reg_we;
    logic       flag_we;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       halted;
  } out_t;

  typedef struct {
    logic [7:0] rdata;
    logic       ack;
    logic       zf;
    out_t       exp;
    logic       h1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic       zero_flag = 1'b0;

  logic       mem_req, ir_load, imm_load, pc_inc, pc_load, a_src_imm, reg_we, flag_we, halted;
  logic [2:0] alu_sel;
  logic [1:0] reg_dst, reg_src;

  logic       d1_mem_req, d1_ir_load, d1_imm_load, d1_pc_inc, d1_pc_load;
  logic       d1_a_src_imm, d1_reg_we, d1_flag_we, d1_halted;
  logic [2:0] d1_alu_sel;
  logic [1:0] d1_reg_dst, d1_reg_src;

  out_t got;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  mpu_control_fsm #(.DATA_W(8), .RSVD_HALTS(1'b0)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .zero_flag(zero_flag), .mem_req(mem_req), .ir_load(ir_load),
    .imm_load(imm_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .alu_sel(alu_sel), .a_src_imm(a_src_imm), .reg_we(reg_we),
    .flag_we(flag_we), .reg_dst(reg_dst), .reg_src(reg_src), .halted(halted)
  );

  mpu_control_fsm #(.DATA_W(8), .RSVD_HALTS(1'b1)) dut_rh (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .zero_flag(zero_flag), .mem_req(d1_mem_req), .ir_load(d1_ir_load),
    .imm_load(d1_imm_load), .pc_inc(d1_pc_inc), .pc_load(d1_pc_load),
    .alu_sel(d1_alu_sel), .a_src_imm(d1_a_src_imm), .reg_we(d1_reg_we),
    .flag_we(d1_flag_we), .reg_dst(d1_reg_dst), .reg_src(d1_reg_src),
    .halted(d1_halted)
  );

  assign got = {mem_req, ir_load, imm_load, pc_inc, pc_load, alu_sel,
                a_src_imm, reg_we, flag_we, reg_dst, reg_src, halted};

  function automatic out_t o(input logic req, input logic irl, input logic imml,
                             input logic inc, input logic ld, input logic [2:0] sel,
                             input logic asrc, input logic we, input logic fwe,
                             input logic [1:0] dst, input logic [1:0] src,
                             input logic hlt);
    return {req, irl, imml, inc, ld, sel, asrc, we, fwe, dst, src, hlt};
  endfunction

  task automatic add(input logic [7:0] rd, input logic ack, input logic zf,
                     input out_t exp, input logic h1);
    vec_t v;
    v.rdata = rd; v.ack = ack; v.zf = zf; v.exp = exp; v.h1 = h1;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input out_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_h1(input string name, input logic exp);
    n_tests++;
    if (d1_halted !== exp) begin
      n_fail++;
      $display("FAIL %s: rsvd-halts halted got %b required %b", name, d1_halted, exp);
    end
  endtask

  initial begin
    // ADD r1,r2 (0x4C); acks in DECODE/EXEC must be ignored
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0), 0); // RESET
    add(8'h4C, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd0,2'd0,0), 0);
    add(8'h00, 1, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd1,2'd2,0), 0);
    add(8'h00, 1, 0, o(0,0,0,0,0,3'd2,0,1,1,2'd1,2'd2,0), 0);
    // LDI r1,#0x5A with two wait states on the immediate
    add(8'hE8, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd1,2'd2,0), 0);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd1,2'd0,0), 0);
    add(8'h00, 0, 0, o(1,0,0,0,0,3'd0,0,0,0,2'd1,2'd0,0), 0);
    add(8'h00, 0, 0, o(1,0,0,0,0,3'd0,0,0,0,2'd1,2'd0,0), 0);
    add(8'h5A, 1, 0, o(1,0,1,1,0,3'd0,0,0,0,2'd1,2'd0,0), 0);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd7,1,1,1,2'd1,2'd0,0), 0);
    // JZ #0x10 taken
    add(8'hE2, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd1,2'd0,0), 0);
    add(8'h00, 0, 1, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h10, 1, 1, o(1,0,1,1,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h00, 0, 1, o(0,0,0,0,1,3'd0,0,0,0,2'd0,2'd1,0), 0);
    // JZ #0x10 not taken; ack in IMM_EXEC ignored
    add(8'hE2, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h10, 1, 0, o(1,0,1,1,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h4C, 1, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    // reserved 0xE4 after one fetch wait: NOP here, halt on the other instance
    add(8'h00, 0, 0, o(1,0,0,0,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'hE4, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd0,2'd1,0), 0);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd2,0), 0);
    // HALT 0xE6, then spurious acks
    add(8'hE6, 1, 0, o(1,1,0,1,0,3'd0,0,0,0,2'd0,2'd2,0), 1);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd3,0), 1);
    add(8'h4C, 1, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd3,1), 1);
    add(8'h00, 0, 0, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd3,1), 1);
    add(8'hE8, 1, 1, o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd3,1), 1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      mem_rdata = vq[i].rdata;
      mem_ack   = vq[i].ack;
      zero_flag = vq[i].zf;
      #1;
      chk($sformatf("row%0d", i), vq[i].exp);
      chk_h1($sformatf("row%0d", i), vq[i].h1);
      @(negedge clk);
    end

    // Reset out of HALT, with a pending ack held through RESET
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h4C; zero_flag = 1'b0;
    #1;
    chk("rst_from_halt", o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    chk_h1("rst_from_halt", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state_ack_ignored", o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("fetch_after_reset", o(1,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'hE6;
    #1;
    chk("fetch_ack_pre_rst", o(1,1,0,1,0,3'd0,0,0,0,2'd0,2'd0,0));
    // Async reset in the middle of an acked fetch cycle
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mid_fetch", o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_after_mid_fetch", o(0,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("fetch_ir_cleared", o(1,0,0,0,0,3'd0,0,0,0,2'd0,2'd0,0));
    chk_h1("rh_fetch_not_halted", 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
